// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer driving the program counter register.
//
// Reads the current pc, issues instruction-memory reads and tells the PC
// register when and where to advance. It also holds the IF/ID output slot,
// applies downstream backpressure, takes redirects from execute, and stops
// fetching for good when decode holds a halt instruction.
//
// Build option: define FETCH_SKID_BUF_EN to add a skid entry behind the
// output slot. This lets a fetch complete while the output is stalled. When
// the macro is undefined, the unit has a single output slot.
module fetch_unit #(
    parameter int unsigned          WORD_W  = 32,
    parameter logic [WORD_W-1:0]    PC_INIT = '0
) (
    input  logic                clk,
    input  logic                n_rst,

    // PC register
    input  logic [WORD_W-1:0]   pc,
    output logic                adv,
    output logic [WORD_W-1:0]   next_pc,

    // instruction memory port
    output logic                imem_ren,
    output logic [WORD_W-1:0]   imem_addr,
    input  logic                imem_ihit,
    input  logic [WORD_W-1:0]   imem_load,

    // control-flow change and halt
    input  logic                redirect,
    input  logic [WORD_W-1:0]   redirect_pc,
    input  logic                halt_in,

    // IF/ID output slot
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WORD_W-1:0]   if_instr,
    output logic [WORD_W-1:0]   if_pc,
    output logic [WORD_W-1:0]   if_npc
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [WORD_W-1:0] PC_STEP    = WORD_W'(4);
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;

    logic               if_valid_reg;
    logic [WORD_W-1:0]  if_instr_reg;
    logic [WORD_W-1:0]  if_pc_reg;
    logic [WORD_W-1:0]  if_npc_reg;

    logic               in_fetch;
    logic               flush_redirect;
    logic               halt_now;
    logic               slot_free;
    logic               capture;
    logic               out_accept;
    logic [WORD_W-1:0]  pc_plus4;

`ifdef FETCH_SKID_BUF_EN
    logic               skid_valid_reg;
    logic [WORD_W-1:0]  skid_instr_reg;
    logic [WORD_W-1:0]  skid_pc_reg;
    logic [WORD_W-1:0]  skid_npc_reg;
`endif

    assign in_fetch       = (state_reg == ST_FETCH);
    // A redirect from execute overrides everything else, including halt.
    assign flush_redirect = in_fetch && redirect;
    assign halt_now       = in_fetch && !redirect && halt_in;
    assign out_accept     = if_valid_reg && if_ready;
    assign pc_plus4       = pc + PC_STEP;

`ifdef FETCH_SKID_BUF_EN
    // The skid entry absorbs one capture while the output is stalled.
    assign slot_free = !skid_valid_reg;
`else
    assign slot_free = !if_valid_reg || if_ready;
`endif

    // Read request, capture, and PC advance are decided combinationally in the same cycle.
    always_comb begin
        imem_ren = in_fetch && slot_free && !redirect && !halt_in;
        capture  = imem_ren && imem_ihit;
        adv      = flush_redirect || capture;
        next_pc  = pc;
        if (flush_redirect) begin
            next_pc = redirect_pc & ALIGN_MASK;
        end else if (capture) begin
            next_pc = pc_plus4;
        end
    end

    assign imem_addr = pc;

    // IDLE moves to FETCH after one cycle. HALTED is left only through reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  if (halt_now) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef FETCH_SKID_BUF_EN
    // Output slot and skid entry. The skid entry always drains first, which preserves order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            if_valid_reg   <= 1'b0;
            if_instr_reg   <= '0;
            if_pc_reg      <= PC_INIT;
            if_npc_reg     <= PC_INIT + PC_STEP;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
            skid_npc_reg   <= '0;
        end else if (flush_redirect || halt_now) begin
            if_valid_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            // No capture can happen here, because a full skid entry blocks imem_ren.
            if (if_ready) begin
                if_valid_reg   <= 1'b1;
                if_instr_reg   <= skid_instr_reg;
                if_pc_reg      <= skid_pc_reg;
                if_npc_reg     <= skid_npc_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (capture) begin
            if (!if_valid_reg || if_ready) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= imem_load;
                if_pc_reg    <= pc;
                if_npc_reg   <= pc_plus4;
            end else begin
                skid_valid_reg <= 1'b1;
                skid_instr_reg <= imem_load;
                skid_pc_reg    <= pc;
                skid_npc_reg   <= pc_plus4;
            end
        end else if (out_accept) begin
            if_valid_reg <= 1'b0;
        end
    end
`else
    // Single output slot: it loads on capture, empties on accept, and is flushed by a redirect or a halt.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            if_valid_reg <= 1'b0;
            if_instr_reg <= '0;
            if_pc_reg    <= PC_INIT;
            if_npc_reg   <= PC_INIT + PC_STEP;
        end else if (flush_redirect || halt_now) begin
            // On a halt, the slot instruction is younger than the halt and is dropped.
            if_valid_reg <= 1'b0;
        end else if (capture) begin
            if_valid_reg <= 1'b1;
            if_instr_reg <= imem_load;
            if_pc_reg    <= pc;
            if_npc_reg   <= pc_plus4;
        end else if (out_accept) begin
            if_valid_reg <= 1'b0;
        end
    end
`endif

    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_pc    = if_pc_reg;
    assign if_npc   = if_npc_reg;

endmodule
